clock_reset_ctrl: RTL
=====================

# clock_reset_ctrl

Synthesizable, parametrised successor to the emulation clock/reset generator: takes one free-running clock and an asynchronous active-low reset and produces `NUM_DOMAINS` staggered, synchronously released domain resets, a run-cycle counter, a heartbeat watchdog with a finish/timeout status byte, and a cycle-windowed trace-dump enable. It sits at the top of the emulation/FPGA harness, between the board clock/reset and the DUT plus trace infrastructure. Status encoding matches the cosim watchdog convention: 0 running, 255 finished, anything else is an error.

## Interface
- `NUM_DOMAINS`, 4: number of independently released reset domains (≥1).
- `STAGGER`, 16: cycles between successive domain releases (≥1).
- `SYNC_STAGES`, 2: reset-deassert synchronizer depth (≥2).
- `CNT_W`, 64: width of cycle counter and dump-window bounds.
- `TIMEOUT_W`, 32: width of watchdog limit and idle counter.

Ports:
- `clock`  in  1  free-running clock.
- `reset`  in  1  reset, asynchronous and active-low.
- `heartbeat`  in  1  progress pulse from DUT/cosim; clears the watchdog idle counter.
- `finish_req`  in  1  successful-end request.
- `timeout_limit`  in  TIMEOUT_W  consecutive non-heartbeat cycles allowed; 0 disables the watchdog.
- `dump_start`  in  CNT_W  first run cycle with dump enabled.
- `dump_end`  in  CNT_W  first run cycle with dump disabled; 0 means no end.
- `domain_reset`  out  NUM_DOMAINS  active-high reset per domain, bit i = domain i.
- `cycle`  out  CNT_W  run-cycle count.
- `wd_status`  out  8  0 running/not started, 255 finished, 1 timeout.
- `dump_en`  out  1  trace dump enable.

## Operation
- FSM states: `RESET` → `SYNC` → `SEQ` → `RUN` → {`DONE` | `FAIL`}.
- `reset` low: asynchronously forces `RESET`, `domain_reset` all 1, `cycle`=0, `wd_status`=0, idle counter=0, `dump_en`=0.
- `SYNC`: `reset` release passes through the `SYNC_STAGES` flop chain; the FSM enters `SEQ` on the edge at which the synchronized reset goes inactive.
- `SEQ`: stagger counter runs from 0; domain i deasserts on the edge where the counter reaches `STAGGER*(i+1)`, in ascending index order, never simultaneously. After the last domain releases, enter `RUN` on the following edge. `heartbeat`/`finish_req` are ignored.
- `RUN`: `cycle` increments every cycle, saturating at all-ones. Idle counter clears on `heartbeat`, otherwise increments (saturating).
- `RUN` → `DONE` when `finish_req`=1; `wd_status`=255.
- `RUN` → `FAIL` when `timeout_limit`≠0 and idle counter == `timeout_limit`−1 with no `heartbeat` that cycle; `wd_status`=1.
- Simultaneous events: `finish_req` beats timeout; `heartbeat` beats timeout.
- `DONE`/`FAIL` are terminal until `reset`; `cycle` frozen, `domain_reset` stays 0.
- `dump_en` = state is `RUN` ∧ `cycle` ≥ `dump_start` ∧ (`dump_end`=0 ∨ `cycle` < `dump_end`). If `dump_end` ≠ 0 and `dump_end` ≤ `dump_start`, dump is never enabled.
- Reset mid-operation (any state): immediate return to `RESET` values, then the full sequence repeats.

## Timing
- Reset assert: outputs change asynchronously, no clock needed.
- Reset deassert to domain 0 release: `SYNC_STAGES` + `STAGGER` edges. Domain i: + `STAGGER*i` more.
- `RUN` entry: 1 edge after the last domain release. `cycle` is 0 in the first `RUN` cycle.
- `finish_req`/timeout to `wd_status` update: 1 edge.
- `dump_en`: combinational from registered state and `cycle`, zero added latency.
- All outputs are registered except `dump_en`.

## Structure
- `clock_reset_pkg`: state enum, `WD_RUNNING`=8'd0, `WD_FINISHED`=8'd255, `WD_TIMEOUT`=8'd1.
- Sub-module `reset_synchronizer` (async assert, `SYNC_STAGES`-deep sync deassert). Everything else lives in `clock_reset_ctrl`.

## Test plan
- Defaults; release `reset` at t0 → `domain_reset` 4'b1111→1110→1100→1000→0000 at edges 18, 34, 50, 66; `RUN` at edge 67 with `cycle`=0.
- `timeout_limit`=5, no `heartbeat` → `wd_status`=1 one edge after the 5th idle `RUN` cycle; `cycle` frozen at 4.
- `timeout_limit`=5, `heartbeat` every 4 cycles for 1000 cycles, then `finish_req` → `wd_status` stays 0, then 255; `cycle`=1000.
- `finish_req` and timeout condition in the same cycle → `wd_status`=255.
- `dump_start`=10, `dump_end`=20 → `dump_en` high for `cycle` 10..19 only. `dump_end`=5 → never high. `dump_end`=0 → high from 10 onward.
- `reset` pulsed low during `SEQ` (after domain 1 released) and again in `DONE` → `domain_reset` all 1 immediately, `wd_status`=0, and the full stagger sequence repeats with identical timing.

Source files
------------

// File: rtl/clock_reset_ctrl_pkg.sv
// Shared types and constants for the emulation clock/reset controller.
package clock_reset_pkg;

  // Controller sequencing: board reset, deassert synchronisation,
  // staggered domain release, free run, then one of two terminal states.
  typedef enum logic [2:0] {
    ST_RESET,
    ST_SYNC,
    ST_SEQ,
    ST_RUN,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Watchdog status byte, shared with the cosim watchdog:
  // 0 running, 255 finished, anything else is an error.
  localparam logic [7:0] WD_RUNNING  = 8'd0;
  localparam logic [7:0] WD_FINISHED = 8'd255;
  localparam logic [7:0] WD_TIMEOUT  = 8'd1;

endpackage

// File: rtl/clock_reset_ctrl_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts through a
// SYNC_STAGES-deep flop chain clocked by the free-running clock.
module reset_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,       // asynchronous, active-low
  output logic rst_n_pre,   // value rst_n_sync takes at the next edge
  output logic rst_n_sync   // synchronized active-low reset
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift a constant 1 through the chain once the board reset lets go.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its input before any of them update; blocking here would
      // collapse the chain into a single stage.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_pre  = sync_q[SYNC_STAGES-2];
  assign rst_n_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_ctrl.sv
// Emulation clock/reset controller: staggered domain reset release,
// run-cycle counter, heartbeat watchdog and cycle-windowed dump enable.
module clock_reset_ctrl
  import clock_reset_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int STAGGER     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 64,
  parameter int TIMEOUT_W   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   heartbeat,
  input  logic                   finish_req,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  input  logic [CNT_W-1:0]       dump_start,
  input  logic [CNT_W-1:0]       dump_end,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic [CNT_W-1:0]       cycle,
  output logic [7:0]             wd_status,
  output logic                   dump_en
);

  // Stagger counter must reach STAGGER*NUM_DOMAINS, the last release point.
  localparam int SEQ_LEN = STAGGER * NUM_DOMAINS;
  localparam int SEQ_W   = $clog2(SEQ_LEN + 1);

  state_t               state_q, state_d;
  logic [SEQ_W-1:0]     stg_q;
  logic [SEQ_W-1:0]     stg_next;
  logic [TIMEOUT_W-1:0] idle_q;
  logic                 sync_pre, sync_now;
  logic                 sync_rise;
  logic                 all_released;
  logic                 timeout_hit;
  logic                 stay_run;

  reset_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset     (reset),
    .rst_n_pre (sync_pre),
    .rst_n_sync(sync_now)
  );

  // The synchronized reset goes inactive on the coming edge.
  assign sync_rise    = sync_pre & ~sync_now;
  assign all_released = (domain_reset == '0);
  assign stg_next     = stg_q + SEQ_W'(1);

  // Idle budget exhausted this cycle; a heartbeat in the same cycle rescues it.
  assign timeout_hit = (timeout_limit != '0)
                    && (idle_q == timeout_limit - TIMEOUT_W'(1))
                    && !heartbeat;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Next-state logic; finish has priority over a watchdog timeout.
  always_comb begin
    // NOTE: state_d gets a value before the case so every path assigns it;
    // a missing default in combinational logic infers a latch.
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = sync_rise ? ST_SEQ : ST_SYNC;
      ST_SYNC:  if (sync_rise) state_d = ST_SEQ;
      ST_SEQ:   if (all_released) state_d = ST_RUN;
      ST_RUN: begin
        if (finish_req)       state_d = ST_DONE;
        else if (timeout_hit) state_d = ST_FAIL;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_RESET;
    endcase
  end

  assign stay_run = (state_q == ST_RUN) && (state_d == ST_RUN);

  // Stagger counter: starts at 0 on SEQ entry, counts until the last release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_q <= '0;
    end else if ((state_q == ST_SEQ) && !all_released) begin
      stg_q <= stg_next;
    end
  end

  // Domain i drops its reset on the edge the counter reaches STAGGER*(i+1).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      domain_reset <= '1;
    end else if (state_q == ST_SEQ) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        if (stg_next == SEQ_W'(STAGGER * (i + 1))) domain_reset[i] <= 1'b0;
      end
    end
  end

  // Run-cycle and idle counters advance only while the run continues,
  // so both freeze on the edge that leaves RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle  <= '0;
      idle_q <= '0;
    end else if (stay_run) begin
      if (cycle != '1) cycle <= cycle + CNT_W'(1);
      if (heartbeat)          idle_q <= '0;
      else if (idle_q != '1)  idle_q <= idle_q + TIMEOUT_W'(1);
    end
  end

  // Watchdog status byte, updated on the edge that leaves RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_status <= WD_RUNNING;
    end else if (state_q == ST_RUN) begin
      if (state_d == ST_DONE)      wd_status <= WD_FINISHED;
      else if (state_d == ST_FAIL) wd_status <= WD_TIMEOUT;
    end
  end

  // Dump window [dump_start, dump_end); dump_end of 0 leaves it open-ended.
  assign dump_en = (state_q == ST_RUN)
                && (cycle >= dump_start)
                && ((dump_end == '0) || (cycle < dump_end));

endmodule
